seq_detect: RTL and testbench
=============================

SEQ_DETECT -- requirements
Module: seq_detect

Interface
REQ-001 SHALL have parameter PAT_W, default 4, pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 8, match-counter width, minimum 1.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port en, input, 1, sample strobe; in is consumed only when en=1.
REQ-006 SHALL have port in, input, 1, serial data bit.
REQ-007 SHALL have port load, input, 1, pattern/mode load strobe.
REQ-008 SHALL have port pat_in, input, PAT_W, new pattern; bit PAT_W-1 is the first bit in time.
REQ-009 SHALL have port ovl_in, input, 1, new mode: 1 = overlapping matches, 0 = non-overlapping.
REQ-010 SHALL have port clr, input, 1, synchronous clear of match_cnt.
REQ-011 SHALL have port match, output, 1, registered one-cycle match pulse.
REQ-012 SHALL have port match_cnt, output, CNT_W, saturating count of matches.
REQ-013 SHALL have port armed, output, 1, high when at least PAT_W valid bits are held (fill = PAT_W).

Function
REQ-014 SHALL keep the registers pat (PAT_W), ovl (1), hist (PAT_W) and fill (0..PAT_W).
REQ-015 On a sample (en=1, load=0), hist SHALL shift left with in entering bit 0, and fill SHALL increment, saturating at PAT_W.
REQ-016 On a sample, a hit SHALL occur when the post-shift hist equals pat and the post-increment fill equals PAT_W.
REQ-017 On a hit, match SHALL be 1 for exactly the clock period following that edge (same-edge registered Mealy output, zero extra latency); otherwise match SHALL be 0.
REQ-018 On a hit with ovl=0, fill SHALL be set to 0 instead of PAT_W; with ovl=1, fill SHALL stay at PAT_W.
REQ-019 With en=0 and load=0, hist, fill and match_cnt SHALL hold, and match SHALL be 0.
REQ-020 When load=1, pat and ovl SHALL take pat_in and ovl_in, hist and fill SHALL clear to 0, and match SHALL be 0; the same-cycle en/in sample SHALL be discarded; match_cnt SHALL be unaffected.
REQ-021 On a hit, match_cnt SHALL increment by 1, saturating at 2^CNT_W-1 (no wrap).
REQ-022 When clr=1, match_cnt SHALL become 0; when clr and a hit occur in the same cycle, match_cnt SHALL become 1.
REQ-023 armed SHALL be derived combinationally from fill == PAT_W.

Reset
REQ-024 While rstn=0, the block SHALL set match=0, match_cnt=0, hist=0, fill=0, pat=0 and ovl=1, asynchronously.
REQ-025 On reset release, the first rising edge SHALL process inputs normally; reset asserted mid-stream SHALL discard all partial progress.

Structure
REQ-026 The shared package seq_pkg SHALL hold the PAT_W/CNT_W defaults and legal-range constants, plus the function clog2 used to size fill.
REQ-027 The block SHALL be a single flat module with no sub-modules; the counter SHALL live in its own always block.

Verification (PAT_W=4)
REQ-028 Overlap test: load pat=1011 with ovl=1, then send 1,0,1,1,0,1,1 with en=1 continuously -> match pulses after bits 4 and 7, and match_cnt=2.
REQ-029 Non-overlap test: repeat REQ-028 with ovl=0 -> a single match after bit 4, match_cnt=1, and fill=3 after bit 7.
REQ-030 Gapped enable: same stream with en=0 for 3 cycles between bits 2 and 3 -> matches identical to REQ-028, and match=0 during the gaps.
REQ-031 Saturation: CNT_W=2, ovl=1, pat=1111, send 8 ones -> match_cnt goes 1,2,3,3,3; then assert clr and a hit in the same cycle -> match_cnt=1.
REQ-032 Reset mid-stream: after 1,0,1, pulse rstn low, then send 1 -> no match, armed=0, pat=0000, match_cnt=0.
REQ-033 Load mid-stream: after 1,0,1, assert load (pat_in=1011) with en=1, in=1, then send 1 -> no match (hist cleared and the sample discarded).

Source files
------------

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared constants and helpers for the serial pattern detector
// Purpose : default widths, legal parameter ranges, and the clog2 helper used
//           to size the fill counter.
// Ports   : none (package)
package seq_pkg;

    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 8;
    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;
    localparam int CNT_W_MIN = 1;

    // Bits needed to hold values 0..v-1; never less than 1 so it can size a vector.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_detect_if.sv
// rtl/seq_detect_if.sv - sample/load/status bundle of the serial pattern detector
// Purpose : groups the data, load and status signals of seq_detect.
// Ports   : en, in, load, pat_in[PAT_W], ovl_in, clr   (master -> slave)
//           match, match_cnt[CNT_W], armed             (slave -> master)
interface seq_detect_if
    import seq_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);

    logic             en;
    logic             in;
    logic             load;
    logic [PAT_W-1:0] pat_in;
    logic             ovl_in;
    logic             clr;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             armed;

    modport master (
        output en, in, load, pat_in, ovl_in, clr,
        input  match, match_cnt, armed
    );

    modport slave (
        input  en, in, load, pat_in, ovl_in, clr,
        output match, match_cnt, armed
    );

endinterface

// File: rtl/seq_detect.sv
// rtl/seq_detect.sv - serial bit-pattern detector with saturating match counter
// Purpose : shifts sampled bits into a history register and flags a match when
//           the last PAT_W samples equal the loaded pattern; supports
//           overlapping and non-overlapping matching.
// Ports   : clk        clock, rising edge
//           rstn       asynchronous active-low reset
//           bus.en     sample strobe          bus.in     serial data bit
//           bus.load   pattern/mode load      bus.pat_in pattern, MSB first in time
//           bus.ovl_in 1 = overlapping mode   bus.clr    clear match counter
//           bus.match  registered match pulse bus.match_cnt saturating match count
//           bus.armed  PAT_W valid bits held
module seq_detect
    import seq_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rstn,
    seq_detect_if.slave  bus
);

    localparam int             FW        = clog2(PAT_W + 1);
    localparam logic [FW-1:0]  FILL_FULL = FW'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX || CNT_W < CNT_W_MIN) begin : g_bad_param
        $error("seq_detect: illegal PAT_W/CNT_W");
    end

    logic [PAT_W-1:0] pat_q,  pat_d;
    logic             ovl_q,  ovl_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [FW-1:0]    fill_inc;
    logic             match_q;
    logic [CNT_W-1:0] cnt_q;
    logic             hit;

    // Next-state: load wins over a sample and discards it.
    always_comb begin
        pat_d    = pat_q;
        ovl_d    = ovl_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        fill_inc = fill_q;
        hit      = 1'b0;
        if (bus.load) begin
            pat_d  = bus.pat_in;
            ovl_d  = bus.ovl_in;
            hist_d = '0;
            fill_d = '0;
        end else if (bus.en) begin
            hist_d   = {hist_q[PAT_W-2:0], bus.in};
            fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + FW'(1);
            // Judge the match on the post-shift history so the pulse has no extra latency.
            hit      = (hist_d == pat_q) && (fill_inc == FILL_FULL);
            // Non-overlapping mode requires a fresh PAT_W bits before the next match.
            fill_d   = (hit && !ovl_q) ? '0 : fill_inc;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pat_q   <= '0;
            ovl_q   <= 1'b1;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= hit;
        end
    end

    // Match counter: clear takes priority but still counts a same-cycle hit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (bus.clr) begin
            cnt_q <= hit ? CNT_W'(1) : '0;
        end else if (hit && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.match     = match_q;
    assign bus.match_cnt = cnt_q;
    assign bus.armed     = (fill_q == FILL_FULL);

endmodule

// File: tb/tb_seq_detect.sv
// tb/tb_seq_detect.sv - self-checking bench for seq_detect
module tb_seq_detect;

    localparam int PW = 4;

    logic          clk;
    logic          rstn;
    logic          en, din, load, ovl_in, clr;
    logic [PW-1:0] pat_in;

    seq_detect_if #(.PAT_W(PW), .CNT_W(8)) b8 ();
    seq_detect_if #(.PAT_W(PW), .CNT_W(2)) b2 ();

    assign b8.en = en;     assign b2.en = en;
    assign b8.in = din;    assign b2.in = din;
    assign b8.load = load; assign b2.load = load;
    assign b8.pat_in = pat_in; assign b2.pat_in = pat_in;
    assign b8.ovl_in = ovl_in; assign b2.ovl_in = ovl_in;
    assign b8.clr = clr;   assign b2.clr = clr;

    seq_detect #(.PAT_W(PW), .CNT_W(8)) dut8 (.clk(clk), .rstn(rstn), .bus(b8));
    seq_detect #(.PAT_W(PW), .CNT_W(2)) dut2 (.clk(clk), .rstn(rstn), .bus(b2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    bit chk_on = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the bits seen since the last clear point, newest at the back.
    bit       hq[$];
    logic [PW-1:0] m_pat;
    bit       m_ovl;
    bit       m_match;
    int       m_c8, m_c2;

    initial begin
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                hq.delete();
                m_pat = '0; m_ovl = 1; m_match = 0; m_c8 = 0; m_c2 = 0;
            end else begin
                bit hit;
                int v;
                hit = 0;
                if (load) begin
                    m_pat = pat_in; m_ovl = ovl_in; hq.delete();
                end else if (en) begin
                    hq.push_back(din);
                    if (hq.size() > PW) void'(hq.pop_front());
                    if (hq.size() == PW) begin
                        v = 0;
                        foreach (hq[i]) v = v * 2 + int'(hq[i]);
                        hit = (v == int'(m_pat));
                    end
                    if (hit && !m_ovl) hq.delete();
                end
                m_match = hit;
                if (clr) begin
                    m_c8 = int'(hit); m_c2 = int'(hit);
                end else if (hit) begin
                    if (m_c8 < 255) m_c8++;
                    if (m_c2 < 3)   m_c2++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("match8", 32'(b8.match), 32'(m_match));
            chk("match2", 32'(b2.match), 32'(m_match));
            chk("cnt8",   32'(b8.match_cnt), 32'(m_c8));
            chk("cnt2",   32'(b2.match_cnt), 32'(m_c2));
            chk("armed",  32'(b8.armed), 32'(hq.size() == PW));
            chk("armed2", 32'(b2.armed), 32'(hq.size() == PW));
        end
    end

    // Drive one cycle of inputs, return at the next falling edge.
    task automatic cyc(input logic e, input logic b, input logic ld, input logic c,
                       input logic [PW-1:0] p = '0, input logic o = 1'b0);
        en = e; din = b; load = ld; clr = c; pat_in = p; ovl_in = o;
        @(negedge clk);
    endtask

    bit s[7] = '{1, 0, 1, 1, 0, 1, 1};
    logic [6:0] mh;
    int exp31[5] = '{1, 2, 3, 3, 3};

    initial begin
        rstn = 1'b0;
        en = 0; din = 0; load = 0; clr = 0; pat_in = '0; ovl_in = 0;
        repeat (3) @(negedge clk);
        chk("rst_match", 32'(b8.match), 0);
        chk("rst_cnt",   32'(b8.match_cnt), 0);
        chk("rst_armed", 32'(b8.armed), 0);
        rstn = 1'b1;
        chk_on = 1;

        // Reset pattern is 0000 in overlap mode.
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        chk("rstpat_match", 32'(b8.match), 1);
        cyc(1, 0, 0, 0);
        chk("rstpat_ovl", 32'(b8.match), 1);

        // Overlapping.
        cyc(0, 0, 1, 1, 4'b1011, 1);
        for (int i = 0; i < 7; i++) begin cyc(1, s[i], 0, 0); mh[i] = b8.match; end
        chk("ovl_vec", 32'(mh), 32'(7'b1001000));
        chk("ovl_cnt", 32'(b8.match_cnt), 2);

        // Non-overlapping.
        cyc(0, 0, 1, 1, 4'b1011, 0);
        for (int i = 0; i < 7; i++) begin cyc(1, s[i], 0, 0); mh[i] = b8.match; end
        chk("novl_vec",   32'(mh), 32'(7'b0001000));
        chk("novl_cnt",   32'(b8.match_cnt), 1);
        chk("novl_armed", 32'(b8.armed), 0);

        // Gapped enable.
        cyc(0, 0, 1, 1, 4'b1011, 1);
        for (int i = 0; i < 7; i++) begin
            if (i == 2) begin
                for (int g = 0; g < 3; g++) begin
                    cyc(0, 1, 0, 0);
                    chk("gap_match", 32'(b8.match), 0);
                end
            end
            cyc(1, s[i], 0, 0);
            mh[i] = b8.match;
        end
        chk("gap_vec", 32'(mh), 32'(7'b1001000));
        chk("gap_cnt", 32'(b8.match_cnt), 2);

        // Saturation on the 2-bit counter.
        cyc(0, 0, 1, 1, 4'b1111, 1);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 0, 0);
            if (i >= 3) chk("sat_cnt2", 32'(b2.match_cnt), 32'(exp31[i-3]));
        end
        chk("sat_cnt8", 32'(b8.match_cnt), 5);
        cyc(1, 1, 0, 1);
        chk("clrhit_cnt2",  32'(b2.match_cnt), 1);
        chk("clrhit_cnt8",  32'(b8.match_cnt), 1);
        chk("clrhit_match", 32'(b2.match), 1);

        // Reset mid-stream.
        cyc(0, 0, 1, 1, 4'b1011, 1);
        cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
        #1 rstn = 1'b0;
        #1;
        chk("midrst_match", 32'(b8.match), 0);
        chk("midrst_cnt",   32'(b8.match_cnt), 0);
        chk("midrst_armed", 32'(b8.armed), 0);
        rstn = 1'b1;
        cyc(1, 1, 0, 0);
        chk("postrst_match", 32'(b8.match), 0);
        chk("postrst_armed", 32'(b8.armed), 0);
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        chk("postrst_nohit", 32'(b8.match), 0);
        cyc(1, 0, 0, 0);
        chk("postrst_pat0", 32'(b8.match), 1);

        // Load mid-stream discards the same-cycle sample.
        cyc(0, 0, 1, 1, 4'b1011, 1);
        cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 0, 4'b1011, 1);
        chk("midload_match", 32'(b8.match), 0);
        cyc(1, 1, 0, 0);
        chk("midload_after", 32'(b8.match), 0);
        chk("midload_armed", 32'(b8.armed), 0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 49) == 0,
                $urandom_range(0, 29) == 0, PW'($urandom), 1'($urandom));
            if ($urandom_range(0, 299) == 0) begin
                #1 rstn = 1'b0;
                #1 rstn = 1'b1;
            end
        end

        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
